// File: rtl/fill_rect_if.sv
// Request and VGA pixel-write signals of the rectangle filler.
// The abort line exists only when FILL_RECT_ABORT_EN is defined.
interface fill_rect_if #(
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned COLOUR_W = 3
);
    logic                start;
    logic [X_W-1:0]      x0;
    logic [Y_W-1:0]      y0;
    logic [X_W-1:0]      w;
    logic [Y_W-1:0]      h;
    logic [COLOUR_W-1:0] colour;
    logic [1:0]          mode;
`ifdef FILL_RECT_ABORT_EN
    logic                abort;
`endif
    logic                done;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;

`ifdef FILL_RECT_ABORT_EN
    modport master (output start, x0, y0, w, h, colour, mode, abort,
                    input  done, vga_x, vga_y, vga_colour, vga_plot);
    modport slave  (input  start, x0, y0, w, h, colour, mode, abort,
                    output done, vga_x, vga_y, vga_colour, vga_plot);
`else
    modport master (output start, x0, y0, w, h, colour, mode,
                    input  done, vga_x, vga_y, vga_colour, vga_plot);
    modport slave  (input  start, x0, y0, w, h, colour, mode,
                    output done, vga_x, vga_y, vga_colour, vga_plot);
`endif
endinterface

// File: rtl/fill_rect.sv
// Clipped, patterned rectangle filler driving the VGA adapter one pixel per clock.
// Optional early stop via abort when FILL_RECT_ABORT_EN is defined.
module fill_rect #(
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120,
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned COLOUR_W = 3
) (
    input logic        clk,
    input logic        rst_n,
    fill_rect_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StLoad, StPlot, StDone} state_e;

    localparam logic [X_W:0] XLim = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] YLim = (Y_W+1)'(SCREEN_H);

    state_e              state_q, state_d;
    logic [X_W-1:0]      x0_q, w_q;
    logic [Y_W-1:0]      y0_q, h_q;
    logic [COLOUR_W-1:0] colour_q;
    logic [1:0]          mode_q;

    // Output registers double as the scan cursor.
    logic [X_W-1:0]      vga_x_q, vga_x_d;
    logic [Y_W-1:0]      vga_y_q, vga_y_d;
    logic [COLOUR_W-1:0] pix_colour_q, pix_colour_d;
    logic                plot_q, plot_d;
    logic                done_q, done_d;

    logic [X_W:0] x_sum, xe;
    logic [Y_W:0] y_sum, ye;
    logic         empty, last_row, last_col, abort_hit;

    assign x_sum    = {1'b0, x0_q} + {1'b0, w_q};
    assign y_sum    = {1'b0, y0_q} + {1'b0, h_q};
    assign xe       = (x_sum > XLim) ? XLim : x_sum;
    assign ye       = (y_sum > YLim) ? YLim : y_sum;
    assign empty    = (w_q == '0) || (h_q == '0) ||
                      ({1'b0, x0_q} >= XLim) || ({1'b0, y0_q} >= YLim);
    assign last_row = ({1'b0, vga_y_q} == ye - (Y_W+1)'(1));
    assign last_col = ({1'b0, vga_x_q} == xe - (X_W+1)'(1));

`ifdef FILL_RECT_ABORT_EN
    assign abort_hit = bus.abort;
`else
    assign abort_hit = 1'b0;
`endif

    function automatic logic [COLOUR_W-1:0] pattern(input logic [1:0]          md,
                                                    input logic [COLOUR_W-1:0] col,
                                                    input logic [X_W-1:0]      x,
                                                    input logic [Y_W-1:0]      y);
        logic [COLOUR_W-1:0] p;
        unique case (md)
            2'd0:    p = col;
            2'd1:    p = COLOUR_W'(x);
            2'd2:    p = COLOUR_W'(y);
            default: p = (x[0] ^ y[0]) ? '0 : col;
        endcase
        return p;
    endfunction

    always_comb begin
        state_d      = state_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        pix_colour_d = pix_colour_q;
        plot_d       = 1'b0;
        done_d       = done_q;
        case (state_q)
            StIdle: begin
                done_d = 1'b0;
                if (bus.start) state_d = StLoad;
            end
            StLoad: begin
                if (empty) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    state_d      = StPlot;
                    plot_d       = 1'b1;
                    vga_x_d      = x0_q;
                    vga_y_d      = y0_q;
                    pix_colour_d = pattern(mode_q, colour_q, x0_q, y0_q);
                end
            end
            StPlot: begin
                if (abort_hit || (last_row && last_col)) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    plot_d = 1'b1;
                    // Column-major: walk down y, then step to the next column.
                    if (last_row) begin
                        vga_y_d = y0_q;
                        vga_x_d = vga_x_q + X_W'(1);
                    end else begin
                        vga_y_d = vga_y_q + Y_W'(1);
                    end
                    pix_colour_d = pattern(mode_q, colour_q, vga_x_d, vga_y_d);
                end
            end
            StDone: begin
                done_d = 1'b1;
                if (!bus.start) begin
                    state_d = StIdle;
                    done_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            pix_colour_q <= '0;
            plot_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            pix_colour_q <= pix_colour_d;
            plot_q       <= plot_d;
            done_q       <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            colour_q <= '0;
            mode_q   <= '0;
        end else if (state_q == StIdle && bus.start) begin
            x0_q     <= bus.x0;
            y0_q     <= bus.y0;
            w_q      <= bus.w;
            h_q      <= bus.h;
            colour_q <= bus.colour;
            mode_q   <= bus.mode;
        end
    end

    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = pix_colour_q;
    assign bus.vga_plot   = plot_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_fill_rect.sv
// Directed bench for fill_rect: full screen, clipping, degenerate, checkerboard,
// reset mid-fill and (with FILL_RECT_ABORT_EN) abort.
module tb_fill_rect;
    localparam int X_W = 8, Y_W = 7, C_W = 3, SW = 160, SH = 120;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fill_rect_if #(.X_W(X_W), .Y_W(Y_W), .COLOUR_W(C_W)) bus ();

    fill_rect #(.SCREEN_W(SW), .SCREEN_H(SH), .X_W(X_W), .Y_W(Y_W), .COLOUR_W(C_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Results of the most recent fill.
    int n_plots, first_cyc, last_cyc, done_cyc;
    int order_err, col_err, oob_err;
    int first_x, first_y, first_c, last_x, last_y;
    int sx [4], sy [4], sc [4];
    logic [C_W-1:0] pix [0:SW-1][0:SH-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_colour(input int md, input int col, input int x, input int y);
        case (md)
            0:       return col;
            1:       return x % 8;
            2:       return y % 8;
            default: return (((x ^ y) & 1) == 0) ? col : 0;
        endcase
    endfunction

    // Requests a fill and watches the pixel stream against a reference scan.
    // Returns on done, after stop_after plots (if nonzero), or on cycle budget.
    task automatic do_fill(input int x0, input int y0, input int w, input int h,
                           input int col, input int md, input int stop_after);
        int ex, ey, xe, ye, px, py;
        bus.x0 = X_W'(x0); bus.y0 = Y_W'(y0); bus.w = X_W'(w); bus.h = Y_W'(h);
        bus.colour = C_W'(col); bus.mode = 2'(md); bus.start = 1'b1;
        xe = (x0 + w > SW) ? SW : x0 + w;
        ye = (y0 + h > SH) ? SH : y0 + h;
        ex = x0; ey = y0;
        n_plots = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
        order_err = 0; col_err = 0; oob_err = 0;
        first_x = -1; first_y = -1; first_c = -1; last_x = -1; last_y = -1;
        for (int cyc = 1; cyc <= 25000; cyc++) begin
            step();
            if (bus.vga_plot === 1'b1) begin
                px = int'(bus.vga_x); py = int'(bus.vga_y);
                if (n_plots == 0) begin
                    first_cyc = cyc; first_x = px; first_y = py; first_c = int'(bus.vga_colour);
                end
                if (n_plots < 4) begin
                    sx[n_plots] = px; sy[n_plots] = py; sc[n_plots] = int'(bus.vga_colour);
                end
                last_cyc = cyc; last_x = px; last_y = py;
                if (px != ex || py != ey) order_err++;
                if (px >= SW || py >= SH) oob_err++;
                else pix[px][py] = bus.vga_colour;
                if (int'(bus.vga_colour) != model_colour(md, col, px, py)) col_err++;
                n_plots++;
                if (ey == ye - 1) begin ey = y0; ex++; end
                else ey++;
                if (stop_after != 0 && n_plots == stop_after) return;
            end
            if (bus.done === 1'b1) begin
                done_cyc = cyc;
                return;
            end
        end
    endtask

    task automatic release_start();
        bus.start = 1'b0;
        step();
        chk("done_clears", 32'(bus.done), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_x"}, 32'(bus.vga_x), 32'd0);
        chk({tag, "_y"}, 32'(bus.vga_y), 32'd0);
        chk({tag, "_colour"}, 32'(bus.vga_colour), 32'd0);
        chk({tag, "_plot"}, 32'(bus.vga_plot), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int cx [4], cy [4], cc [4];
        cx = '{4, 4, 5, 5}; cy = '{4, 5, 4, 5}; cc = '{6, 0, 0, 6};
        rst_n = 1'b0;
        bus.start = 1'b0; bus.x0 = '0; bus.y0 = '0; bus.w = '0; bus.h = '0;
        bus.colour = '0; bus.mode = '0;
`ifdef FILL_RECT_ABORT_EN
        bus.abort = 1'b0;
`endif
        step(); step();
        chk_zero("reset");
        rst_n = 1'b1;
        step();

        // Full screen, column stripes
        do_fill(0, 0, 160, 120, 0, 1, 0);
        chk("full_plots", 32'(n_plots), 32'd19200);
        chk("full_first_cyc", 32'(first_cyc), 32'd2);
        chk("full_first_x", 32'(first_x), 32'd0);
        chk("full_first_y", 32'(first_y), 32'd0);
        chk("full_first_c", 32'(first_c), 32'd0);
        chk("full_pix_9_5", 32'(pix[9][5]), 32'd1);
        chk("full_pix_159_119", 32'(pix[159][119]), 32'd7);
        chk("full_order", 32'(order_err), 32'd0);
        chk("full_colour", 32'(col_err), 32'd0);
        chk("full_gapless", 32'(last_cyc - first_cyc + 1), 32'd19200);
        chk("full_done_cyc", 32'(done_cyc), 32'(last_cyc + 1));
        step();
        chk("full_done_hold", 32'(bus.done), 32'd1);
        chk("full_hold_noplot", 32'(bus.vga_plot), 32'd0);
        chk("full_hold_x", 32'(bus.vga_x), 32'd159);
        release_start();

        // Clipped at bottom-right corner
        do_fill(150, 110, 20, 20, 5, 0, 0);
        chk("clip_plots", 32'(n_plots), 32'd100);
        chk("clip_colour", 32'(col_err), 32'd0);
        chk("clip_oob", 32'(oob_err), 32'd0);
        chk("clip_order", 32'(order_err), 32'd0);
        chk("clip_first_x", 32'(first_x), 32'd150);
        chk("clip_first_y", 32'(first_y), 32'd110);
        chk("clip_last_x", 32'(last_x), 32'd159);
        chk("clip_last_y", 32'(last_y), 32'd119);
        release_start();

        // Degenerate: zero width, then origin off screen
        do_fill(10, 10, 0, 10, 3, 0, 0);
        chk("degen_plots", 32'(n_plots), 32'd0);
        chk("degen_done_cyc", 32'(done_cyc), 32'd2);
        release_start();
        do_fill(200, 0, 5, 5, 3, 0, 0);
        chk("offscreen_plots", 32'(n_plots), 32'd0);
        chk("offscreen_done_cyc", 32'(done_cyc), 32'd2);
        release_start();

        // Checkerboard 2x2
        do_fill(4, 4, 2, 2, 6, 3, 0);
        chk("chk_plots", 32'(n_plots), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("chk_x%0d", i), 32'(sx[i]), 32'(cx[i]));
            chk($sformatf("chk_y%0d", i), 32'(sy[i]), 32'(cy[i]));
            chk($sformatf("chk_c%0d", i), 32'(sc[i]), 32'(cc[i]));
        end
        chk("chk_done_cyc", 32'(done_cyc), 32'(last_cyc + 1));
        release_start();

        // Reset in the middle of a full-screen fill
        do_fill(0, 0, 160, 120, 0, 1, 50);
        chk("rst_pre_plots", 32'(n_plots), 32'd50);
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        step();
        rst_n = 1'b1;
        do_fill(0, 0, 160, 120, 0, 1, 0);
        chk("rst_plots", 32'(n_plots), 32'd19200);
        chk("rst_first_cyc", 32'(first_cyc), 32'd2);
        chk("rst_first_x", 32'(first_x), 32'd0);
        chk("rst_first_y", 32'(first_y), 32'd0);
        chk("rst_done_cyc", 32'(done_cyc), 32'(last_cyc + 1));
        release_start();

`ifdef FILL_RECT_ABORT_EN
        // Abort after 10 plots
        do_fill(0, 0, 160, 120, 0, 1, 10);
        chk("abort_pre_plots", 32'(n_plots), 32'd10);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_noplot", 32'(bus.vga_plot), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd1);
        begin
            int extra = 0;
            for (int i = 0; i < 5; i++) begin
                step();
                if (bus.vga_plot === 1'b1) extra++;
            end
            chk("abort_no_more_plots", 32'(extra), 32'd0);
        end
        chk("abort_done_hold", 32'(bus.done), 32'd1);
        release_start();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
